// File: rtl/ml_ahb_pkg.sv
// Shared AHB constants, arbiter state type and burst-length helper
// for the multilayer AHB matrix slave-port arbiters.
package ml_ahb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OWNED,
      ST_LOCKED
   } arb_state_t;

   // Remaining SEQ beats after the NONSEQ of a defined-length burst
   function automatic logic [3:0] burst_beats(input logic [2:0] hb);
      logic [3:0] n;
      n = 4'd0;
      case (hb)
         HBURST_WRAP4,  HBURST_INCR4:  n = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  n = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: n = 4'd15;
         default:                      n = 4'd0;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ml_ahb_port_arbiter_if.sv
// Master-side request and arbitration-result bundle of one slave port.
// The arbiter takes the slave modport; the driving side takes master.
interface ml_ahb_port_arbiter_if #(
   parameter int NUM_MASTERS = 2,
   parameter int PRIO_W      = 1
);
   logic                          round_robin;
   logic [NUM_MASTERS*PRIO_W-1:0] priority_level;
   logic [NUM_MASTERS-1:0]        mx_hsel;
   logic [2*NUM_MASTERS-1:0]      mx_htrans;
   logic [3*NUM_MASTERS-1:0]      mx_hburst;
   logic                          hready;
   logic [NUM_MASTERS-1:0]        addr_grant;
   logic [NUM_MASTERS-1:0]        data_owner;
   logic                          data_valid;
   logic [NUM_MASTERS-1:0]        mx_wait;

   modport master (
      output round_robin, priority_level, mx_hsel,
      output mx_htrans, mx_hburst, hready,
      input  addr_grant, data_owner, data_valid, mx_wait
   );

   modport slave (
      input  round_robin, priority_level, mx_hsel,
      input  mx_htrans, mx_hburst, hready,
      output addr_grant, data_owner, data_valid, mx_wait
   );
endinterface

// File: rtl/ml_ahb_rr_picker.sv
// One-hot winner picker: rotating after i_last, or highest level
// with ties to the lowest index. Purely combinational.
module ml_ahb_rr_picker #(
   parameter int N      = 2,
   parameter int PRIO_W = 1,
   parameter int IW     = 1
) (
   input  logic [N-1:0]        i_req,
   input  logic [N*PRIO_W-1:0] i_levels,
   input  logic [IW-1:0]       i_last,
   input  logic                i_rr,
   output logic [N-1:0]        o_winner
);
   logic              w_found;
   logic [PRIO_W-1:0] w_best;
   logic [PRIO_W-1:0] w_lvl;
   int                w_idx;

   always_comb begin
      o_winner = '0;
      w_found  = 1'b0;
      w_best   = '0;
      w_lvl    = '0;
      w_idx    = 0;
      if (i_rr) begin
         for (int k = 1; k <= N; k++) begin
            w_idx = (int'(i_last) + k) % N;
            if (!w_found && i_req[w_idx]) begin
               o_winner[w_idx] = 1'b1;
               w_found         = 1'b1;
            end
         end
      end else begin
         for (int i = 0; i < N; i++) begin
            w_lvl = i_levels[i*PRIO_W +: PRIO_W];
            if (i_req[i] && (!w_found || w_lvl > w_best)) begin
               w_idx   = i;
               w_best  = w_lvl;
               w_found = 1'b1;
            end
         end
         if (w_found) o_winner[w_idx] = 1'b1;
      end
   end
endmodule

// File: rtl/ml_ahb_port_arbiter.sv
// Per-slave-port arbiter: address-phase grant, burst lock,
// data-phase owner tracking and per-master wait generation.
module ml_ahb_port_arbiter
   import ml_ahb_pkg::*;
#(
   parameter int NUM_MASTERS = 2,
   parameter int PRIO_W      = 1
) (
   input logic                  hclk,
   input logic                  resetn,
   ml_ahb_port_arbiter_if.slave io_bus
);
   localparam int N  = NUM_MASTERS;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   arb_state_t    r_state, w_state_nxt;
   logic [N-1:0]  r_grant, w_grant_nxt;
   logic [N-1:0]  r_downer, w_downer_nxt;
   logic          r_dvalid, w_dvalid_nxt;
   logic [3:0]    r_cnt, w_cnt_nxt;
   logic [IW-1:0] r_last, w_last_nxt;
   logic          r_first, w_first_nxt;
   logic          r_incr, w_incr_nxt;

   logic [N-1:0]  w_req;
   logic [N-1:0]  w_winner;
   logic [1:0]    w_own_trans;
   logic [2:0]    w_win_burst;
   logic [IW-1:0] w_win_idx;
   logic          w_arb;

   always_comb begin
      w_req = '0;
      for (int x = 0; x < N; x++)
         w_req[x] = io_bus.mx_hsel[x] &&
            (io_bus.mx_htrans[2*x +: 2] == HTRANS_NONSEQ);
   end

   // A deselected owner is treated as driving IDLE to this port
   always_comb begin
      w_own_trans = HTRANS_IDLE;
      w_win_burst = HBURST_SINGLE;
      w_win_idx   = '0;
      for (int x = 0; x < N; x++) begin
         if (r_grant[x] && io_bus.mx_hsel[x])
            w_own_trans = io_bus.mx_htrans[2*x +: 2];
         if (w_winner[x]) begin
            w_win_burst = io_bus.mx_hburst[3*x +: 3];
            w_win_idx   = IW'(x);
         end
      end
   end

   ml_ahb_rr_picker #(
      .N      (N),
      .PRIO_W (PRIO_W),
      .IW     (IW)
   ) u_picker (
      .i_req    (w_req),
      .i_levels (io_bus.priority_level),
      .i_last   (r_last),
      .i_rr     (io_bus.round_robin),
      .o_winner (w_winner)
   );

   // r_first masks the owner's own opening NONSEQ inside a burst
   always_comb begin
      w_arb = 1'b0;
      unique case (r_state)
         ST_IDLE:   w_arb = 1'b1;
         ST_OWNED:  w_arb = 1'b1;
         ST_LOCKED: w_arb =
            (w_own_trans == HTRANS_IDLE) ||
            (w_own_trans == HTRANS_NONSEQ && !r_first) ||
            (!r_incr && w_own_trans == HTRANS_SEQ &&
             r_cnt == 4'd1);
         default:   w_arb = 1'b1;
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_grant_nxt  = r_grant;
      w_cnt_nxt    = r_cnt;
      w_last_nxt   = r_last;
      w_first_nxt  = r_first;
      w_incr_nxt   = r_incr;
      w_downer_nxt = '0;
      w_dvalid_nxt = 1'b0;
      if (w_arb) begin
         w_grant_nxt = w_winner;
         if (|w_winner) begin
            w_last_nxt  = w_win_idx;
            w_first_nxt = 1'b1;
            w_incr_nxt  = (w_win_burst == HBURST_INCR);
            w_cnt_nxt   = burst_beats(w_win_burst);
            w_state_nxt = (w_win_burst == HBURST_SINGLE) ?
                          ST_OWNED : ST_LOCKED;
         end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 4'd0;
            w_first_nxt = 1'b0;
            w_incr_nxt  = 1'b0;
         end
      end else begin
         w_first_nxt = 1'b0;
         if (!r_incr && w_own_trans == HTRANS_SEQ && r_cnt != 4'd0)
            w_cnt_nxt = r_cnt - 4'd1;
      end
      if (|r_grant && w_own_trans[1]) begin
         w_downer_nxt = r_grant;
         w_dvalid_nxt = 1'b1;
      end
   end

   always_ff @(posedge hclk) begin
      if (!resetn) begin
         r_state  <= ST_IDLE;
         r_grant  <= '0;
         r_downer <= '0;
         r_dvalid <= 1'b0;
         r_cnt    <= 4'd0;
         r_last   <= IW'(N - 1);
         r_first  <= 1'b0;
         r_incr   <= 1'b0;
      end else if (io_bus.hready) begin
         r_state  <= w_state_nxt;
         r_grant  <= w_grant_nxt;
         r_downer <= w_downer_nxt;
         r_dvalid <= w_dvalid_nxt;
         r_cnt    <= w_cnt_nxt;
         r_last   <= w_last_nxt;
         r_first  <= w_first_nxt;
         r_incr   <= w_incr_nxt;
      end
   end

   assign io_bus.addr_grant = r_grant;
   assign io_bus.data_owner = r_downer;
   assign io_bus.data_valid = r_dvalid;
   assign io_bus.mx_wait    = w_req & ~r_grant;

endmodule

// File: tb/tb_ml_ahb_port_arbiter.sv
// Directed bench for ml_ahb_port_arbiter with two masters: grant order,
// priority, burst lock, stalls, INCR termination and mid-burst reset.
module tb_ml_ahb_port_arbiter;
   import ml_ahb_pkg::*;

   logic hclk = 1'b0;
   logic resetn;
   int   n_cmp = 0;
   int   n_bad = 0;

   ml_ahb_port_arbiter_if #(.NUM_MASTERS(2), .PRIO_W(1)) bus ();

   ml_ahb_port_arbiter #(.NUM_MASTERS(2), .PRIO_W(1)) dut (
      .hclk   (hclk),
      .resetn (resetn),
      .io_bus (bus)
   );

   always #5 hclk = ~hclk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic step();
      @(posedge hclk);
      #2;
   endtask

   task automatic drv(input int x, input logic s,
                      input logic [1:0] t, input logic [2:0] b);
      bus.mx_hsel[x]        = s;
      bus.mx_htrans[2*x +: 2] = t;
      bus.mx_hburst[3*x +: 3] = b;
   endtask

   task automatic idle_all();
      drv(0, 1'b0, HTRANS_IDLE, HBURST_SINGLE);
      drv(1, 1'b0, HTRANS_IDLE, HBURST_SINGLE);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      bus.round_robin = 1'b1;
      bus.priority_level = 2'b00;
      bus.hready = 1'b1;
      idle_all();
      step();
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b00) begin
         n_bad++;
         $display("FAIL rst_grant got %b exp 00", bus.addr_grant);
      end
      n_cmp++;
      if (bus.data_owner !== 2'b00 || bus.data_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_data got %b/%b exp 00/0",
                  bus.data_owner, bus.data_valid);
      end
      n_cmp++;
      if (bus.mx_wait !== 2'b00) begin
         n_bad++;
         $display("FAIL rst_wait got %b exp 00", bus.mx_wait);
      end
      resetn = 1'b1;
   endtask

   task automatic test_rr_single();
      bus.round_robin = 1'b1;
      drv(0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
      drv(1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
      #1;
      n_cmp++;
      if (bus.mx_wait !== 2'b11) begin
         n_bad++;
         $display("FAIL rr_wait0 got %b exp 11", bus.mx_wait);
      end
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b01) begin
         n_bad++;
         $display("FAIL rr_grant1 got %b exp 01", bus.addr_grant);
      end
      n_cmp++;
      if (bus.mx_wait !== 2'b10) begin
         n_bad++;
         $display("FAIL rr_wait1 got %b exp 10", bus.mx_wait);
      end
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b10) begin
         n_bad++;
         $display("FAIL rr_grant2 got %b exp 10", bus.addr_grant);
      end
      n_cmp++;
      if (bus.data_owner !== 2'b01 || bus.data_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL rr_data2 got %b/%b exp 01/1",
                  bus.data_owner, bus.data_valid);
      end
      drv(0, 1'b0, HTRANS_IDLE, HBURST_SINGLE);
      step();
      drv(1, 1'b0, HTRANS_IDLE, HBURST_SINGLE);
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b00 || bus.data_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL rr_release got %b/%b exp 00/0",
                  bus.addr_grant, bus.data_valid);
      end
   endtask

   task automatic test_priority();
      bus.round_robin = 1'b0;
      bus.priority_level = 2'b10;
      drv(0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
      drv(1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
      for (int c = 0; c < 3; c++) begin
         step();
         #1;
         n_cmp++;
         if (bus.addr_grant !== 2'b10 || bus.mx_wait !== 2'b01) begin
            n_bad++;
            $display("FAIL prio_c%0d got %b/%b exp 10/01",
                     c, bus.addr_grant, bus.mx_wait);
         end
      end
      bus.priority_level = 2'b00;
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b01) begin
         n_bad++;
         $display("FAIL prio_tie got %b exp 01", bus.addr_grant);
      end
      idle_all();
      step();
      bus.round_robin = 1'b1;
   endtask

   task automatic test_burst_lock();
      drv(0, 1'b1, HTRANS_NONSEQ, HBURST_INCR4);
      step();
      step();
      drv(0, 1'b1, HTRANS_SEQ, HBURST_INCR4);
      drv(1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
      for (int b = 2; b <= 4; b++) begin
         #1;
         n_cmp++;
         if (bus.addr_grant !== 2'b01 || bus.mx_wait !== 2'b10) begin
            n_bad++;
            $display("FAIL lock_beat%0d got %b/%b exp 01/10",
                     b, bus.addr_grant, bus.mx_wait);
         end
         step();
      end
      n_cmp++;
      if (bus.addr_grant !== 2'b10) begin
         n_bad++;
         $display("FAIL lock_handover got %b exp 10", bus.addr_grant);
      end
      n_cmp++;
      if (bus.data_owner !== 2'b01 || bus.data_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL lock_data got %b/%b exp 01/1",
                  bus.data_owner, bus.data_valid);
      end
      idle_all();
      step();
      step();
   endtask

   task automatic test_stall();
      drv(0, 1'b1, HTRANS_NONSEQ, HBURST_INCR8);
      step();
      for (int b = 1; b <= 8; b++) begin
         drv(0, 1'b1, (b == 1) ? HTRANS_NONSEQ : HTRANS_SEQ,
             HBURST_INCR8);
         if (b == 5) begin
            bus.hready = 1'b0;
            repeat (3) step();
            n_cmp++;
            if (bus.addr_grant !== 2'b01 || bus.data_owner !== 2'b01 ||
                bus.data_valid !== 1'b1) begin
               n_bad++;
               $display("FAIL stall_hold got %b/%b/%b exp 01/01/1",
                        bus.addr_grant, bus.data_owner, bus.data_valid);
            end
            n_cmp++;
            if (dut.r_cnt !== 4'd4) begin
               n_bad++;
               $display("FAIL stall_cnt got %0d exp 4", dut.r_cnt);
            end
            bus.hready = 1'b1;
         end
         if (b == 8) begin
            n_cmp++;
            if (bus.addr_grant !== 2'b01) begin
               n_bad++;
               $display("FAIL stall_beat8 got %b exp 01",
                        bus.addr_grant);
            end
         end
         step();
      end
      n_cmp++;
      if (bus.addr_grant !== 2'b00 || bus.data_owner !== 2'b01) begin
         n_bad++;
         $display("FAIL stall_end got %b/%b exp 00/01",
                  bus.addr_grant, bus.data_owner);
      end
      idle_all();
      step();
   endtask

   task automatic test_incr_term();
      drv(0, 1'b1, HTRANS_NONSEQ, HBURST_INCR);
      step();
      drv(1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
      step();
      drv(0, 1'b1, HTRANS_BUSY, HBURST_INCR);
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b01) begin
         n_bad++;
         $display("FAIL incr_busy got %b exp 01", bus.addr_grant);
      end
      drv(0, 1'b1, HTRANS_SEQ, HBURST_INCR);
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b01 || bus.data_valid !== 1'b1) begin
         n_bad++;
         $display("FAIL incr_seq got %b/%b exp 01/1",
                  bus.addr_grant, bus.data_valid);
      end
      drv(0, 1'b1, HTRANS_IDLE, HBURST_INCR);
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b10 || bus.data_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL incr_idle got %b/%b exp 10/0",
                  bus.addr_grant, bus.data_valid);
      end
      idle_all();
      step();
      step();
   endtask

   task automatic test_reset_mid_burst();
      drv(0, 1'b1, HTRANS_NONSEQ, HBURST_WRAP8);
      step();
      step();
      drv(0, 1'b1, HTRANS_SEQ, HBURST_WRAP8);
      drv(1, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
      step();
      step();
      resetn = 1'b0;
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b00 || bus.data_owner !== 2'b00 ||
          bus.data_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL mrst_out got %b/%b/%b exp 00/00/0",
                  bus.addr_grant, bus.data_owner, bus.data_valid);
      end
      n_cmp++;
      if (dut.r_state !== ST_IDLE || dut.r_cnt !== 4'd0) begin
         n_bad++;
         $display("FAIL mrst_state got %0d/%0d exp 0/0",
                  dut.r_state, dut.r_cnt);
      end
      drv(0, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
      resetn = 1'b1;
      step();
      n_cmp++;
      if (bus.addr_grant !== 2'b01) begin
         n_bad++;
         $display("FAIL mrst_first got %b exp 01", bus.addr_grant);
      end
      idle_all();
      step();
   endtask

   initial begin
      test_reset();
      test_rr_single();
      test_priority();
      test_burst_lock();
      test_stall();
      test_incr_term();
      test_reset_mid_burst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
